// File: rtl/code_serializer.sv
// Buffers parallel code words in a small FIFO and shifts each one MSB-first onto a
// sequence detector's serial input, returning the detector's verdict per word.
module code_serializer #(
    parameter int   CODE_W   = 11,
    parameter int   DEPTH    = 4,
    parameter int   GAP_CYC  = 2,
    parameter logic IDLE_BIT = 1'b0,
    parameter int   CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_data,
    output logic              ser_bit,
    output logic              ser_active,
    input  logic              det_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_match,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  match_cnt
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid holds
    // its payload stable until then, and ready never depends on valid.
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CODE_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(CODE_W - 1);
    localparam int GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [3:0] GAP_LAST = 4'(GAP_LAST_I);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push, pop;

    logic [CODE_W-1:0] shreg;
    logic [BW-1:0]     bit_idx;
    logic [3:0]        gap_cnt;
    logic              last_bit;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign code_ready = !full;
    assign push       = code_valid && !full;

    assign last_bit   = (state_q == SHIFT) && (bit_idx == BIT_LAST);
    assign ser_active = (state_q == SHIFT);
    assign ser_bit    = (state_q == SHIFT) ? shreg[CODE_W-1] : IDLE_BIT;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending result blocks new words unless it is consumed on this edge.
                if (!empty && (!res_valid || res_ready)) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) state_d = (GAP_CYC > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= code_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            word_cnt  <= '0;
            match_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;

            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                shreg   <= mem[rd_ptr[AW-1:0]];
                bit_idx <= '0;
            end else if (state_q == SHIFT) begin
                shreg   <= {shreg[CODE_W-2:0], 1'b0};
                bit_idx <= bit_idx + 1'b1;
            end

            if (last_bit)             gap_cnt <= '0;
            else if (state_q == GAP)  gap_cnt <= gap_cnt + 1'b1;

            // det_out is combinational from ser_bit, so it is sampled while the last bit is out.
            if (last_bit) begin
                res_valid <= 1'b1;
                res_match <= det_out;
                if (word_cnt != '1)             word_cnt  <= word_cnt + 1'b1;
                if (det_out && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_code_serializer.sv
// Directed bench for code_serializer with a behavioural 11-bit sequence detector on ser_bit.
module tb_code_serializer;
    localparam int CODE_W = 11;
    localparam int CNT_W  = 8;
    localparam logic [CODE_W-1:0] PATTERN = 11'b00010010100;

    logic              clk = 1'b0;
    logic              rst;
    logic              code_valid, code_ready;
    logic [CODE_W-1:0] code_data;
    logic              ser_bit, ser_active, det_out;
    logic              res_valid, res_ready, res_match;
    logic [CNT_W-1:0]  word_cnt, match_cnt;

    code_serializer #(.CODE_W(CODE_W), .DEPTH(4), .GAP_CYC(2), .IDLE_BIT(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_ready(code_ready),
        .code_data(code_data), .ser_bit(ser_bit), .ser_active(ser_active), .det_out(det_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .word_cnt(word_cnt), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Detector model: matches when the last 11 serial bits (including the current one) equal PATTERN.
    logic [CODE_W-2:0] hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= '0;
        else     hist <= {hist[CODE_W-3:0], ser_bit};
    end
    assign det_out = ({hist, ser_bit} == PATTERN);

    // Serial-side monitor, sampled on the falling edge.
    logic [CODE_W-1:0] cur_word;
    int                cur_n = 0;
    int                act_total = 0;
    int                rv_total = 0;
    logic [CODE_W-1:0] got_words [$];
    logic              act_log [$];
    always @(negedge clk) begin
        if (rst) begin
            cur_n = 0;
        end else if (ser_active) begin
            cur_word = {cur_word[CODE_W-2:0], ser_bit};
            cur_n++;
            act_total++;
            if (cur_n == CODE_W) begin
                got_words.push_back(cur_word);
                cur_n = 0;
            end
        end
        act_log.push_back(ser_active);
        if (res_valid) rv_total++;
    end

    int checks = 0;
    int errors = 0;
    logic [CODE_W-1:0] exp_q [$];

    typedef struct {
        logic [CODE_W-1:0] code;
        logic              match;
        int                wc;
        int                mc;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        code_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [CODE_W-1:0] c);
        bit ok;
        ok = 1'b0;
        code_valid = 1'b1;
        code_data  = c;
        for (int n = 0; n < 60; n++) begin
            if (code_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        code_valid = 1'b0;
        if (!ok) check("push_accept", 0, 1);
    endtask

    task automatic wait_res(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check("res_timeout", 0, 1);
    endtask

    task automatic send_and_check(input vec_t v);
        logic [CODE_W-1:0] bits;
        int  nact, first_idx, res_idx;
        bits = '0; nact = 0; first_idx = -1; res_idx = -1;
        push_word(v.code);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ser_active) begin
                if (first_idx < 0) first_idx = i;
                bits = {bits[CODE_W-2:0], ser_bit};
                nact++;
            end
            if (res_valid) begin
                res_idx = i;
                break;
            end
        end
        check("first_bit_latency", first_idx, 0);
        check("serial_bits", int'(bits), int'(v.code));
        check("active_cycles", nact, CODE_W);
        check("res_valid_latency", res_idx, CODE_W);
        check("res_match", int'(res_match), int'(v.match));
        check("word_cnt", int'(word_cnt), v.wc);
        check("match_cnt", int'(match_cnt), v.mc);
    endtask

    initial begin
        int base, i0, r1, r0, r2, base_act, base_rv;
        bit seen, ok;

        vecs[0] = '{PATTERN,        1'b1, 1, 1};
        vecs[1] = '{11'b00000000000, 1'b0, 2, 1};
        vecs[2] = '{11'b11111111111, 1'b0, 3, 1};
        vecs[3] = '{PATTERN,        1'b1, 4, 2};
        vecs[4] = '{11'b10010010100, 1'b0, 5, 2};
        vecs[5] = '{11'b10101010101, 1'b0, 6, 2};

        code_data = '0;
        res_ready = 1'b1;
        do_reset();

        check("rst_code_ready", int'(code_ready), 1);
        check("rst_ser_bit", int'(ser_bit), 0);
        check("rst_ser_active", int'(ser_active), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_match", int'(res_match), 0);
        check("rst_word_cnt", int'(word_cnt), 0);
        check("rst_match_cnt", int'(match_cnt), 0);

        // Table of single words, each fully shifted and its result consumed.
        for (int k = 0; k < 6; k++) begin
            send_and_check(vecs[k]);
            repeat (4) tick();
        end

        // Two queued words: 2 gap cycles plus 1 idle cycle between them.
        base = act_log.size();
        push_word(11'b10000000001);
        push_word(11'b11000000011);
        repeat (45) tick();
        i0 = base;
        while (i0 < act_log.size() && !act_log[i0]) i0++;
        r1 = 0; while (i0 < act_log.size() && act_log[i0])  begin r1++; i0++; end
        r0 = 0; while (i0 < act_log.size() && !act_log[i0]) begin r0++; i0++; end
        r2 = 0; while (i0 < act_log.size() && act_log[i0])  begin r2++; i0++; end
        check("gap_word1_len", r1, CODE_W);
        check("gap_idle_cycles", r0, 3);
        check("gap_word2_len", r2, CODE_W);

        // Result backpressure fills the FIFO and stalls the shifter.
        do_reset();
        res_ready = 1'b0;
        base = got_words.size();
        exp_q = '{PATTERN, 11'h123, 11'h456, 11'h7AB, 11'h0F0};
        push_word(exp_q[0]);
        wait_res(seen);
        check("bp_res_match", int'(res_match), 1);
        for (int k = 1; k < 5; k++) push_word(exp_q[k]);
        check("bp_full_ready", int'(code_ready), 0);
        code_valid = 1'b1;
        code_data  = exp_q[4 + 0];
        base_act = act_total;
        repeat (8) tick();
        check("bp_stall_active", act_total - base_act, 0);
        check("bp_still_full", int'(code_ready), 0);
        check("bp_res_held", int'(res_valid), 1);
        check("bp_match_held", int'(res_match), 1);
        res_ready = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (code_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        code_valid = 1'b0;
        check("bp_fifth_accepted", int'(ok), 1);
        exp_q.push_back(exp_q[4]);
        repeat (100) tick();
        check("bp_word_count", got_words.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < got_words.size())
                check("bp_word", int'(got_words[base + k]), int'(exp_q[k]));
        end
        check("bp_word_cnt", int'(word_cnt), 6);

        // Reset during the 5th bit of a word with more words buffered.
        base_act = act_total;
        push_word(PATTERN);
        push_word(11'h3C3);
        push_word(11'h555);
        for (int n = 0; n < 30 && act_total - base_act < 5; n++) tick();
        check("mid_reached_bit5", act_total - base_act, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_ser_active", int'(ser_active), 0);
        check("mid_rst_ser_bit", int'(ser_bit), 0);
        check("mid_rst_res_valid", int'(res_valid), 0);
        check("mid_rst_code_ready", int'(code_ready), 1);
        check("mid_rst_word_cnt", int'(word_cnt), 0);
        check("mid_rst_match_cnt", int'(match_cnt), 0);
        tick();
        rst = 1'b0;
        base_act = act_total;
        base_rv  = rv_total;
        repeat (40) tick();
        check("post_rst_no_shift", act_total - base_act, 0);
        check("post_rst_no_result", rv_total - base_rv, 0);

        // Counter saturation.
        do_reset();
        for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
            push_word(PATTERN);
            wait_res(seen);
            if (!seen) break;
            if (k == 254) begin
                check("sat_word_cnt_255", int'(word_cnt), 255);
                check("sat_match_cnt_255", int'(match_cnt), 255);
            end
            tick();
        end
        check("sat_word_cnt", int'(word_cnt), 255);
        check("sat_match_cnt", int'(match_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
